// File: rtl/instr_pkg.sv
// Shared ISA definitions for the instruction encoder and the ID stage:
// class codes, opcode constants, field positions, legality and packing.
package instr_pkg;

    typedef enum logic [1:0] {
        CLS_DIMM = 2'b00,
        CLS_DREG = 2'b01,
        CLS_LS   = 2'b10,
        CLS_SYS  = 2'b11
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    localparam logic [4:0] OP_MOV    = 5'b00000;
    localparam logic [4:0] OP_MOVT   = 5'b00001;
    localparam logic [4:0] OP_NOT    = 5'b10110;
    localparam logic [3:0] SYS_B     = 4'b0000;
    localparam logic [3:0] SYS_BCOND = 4'b0001;
    localparam logic [3:0] SYS_BR    = 4'b0010;
    localparam logic [3:0] SYS_NOP   = 4'b0100;
    localparam logic [3:0] SYS_HALT  = 4'b1000;

    localparam int unsigned CLS_LO  = 30;
    localparam int unsigned OP_LO   = 25;
    localparam int unsigned RD_LO   = 22;
    localparam int unsigned RS1_LO  = 19;
    localparam int unsigned RS2_LO  = 16;
    localparam int unsigned COND_LO = 21;

    typedef struct packed {
        instr_class_e cls;
        logic [4:0]   op;
        logic [2:0]   rd;
        logic [2:0]   rs1;
        logic [2:0]   rs2;
        logic [3:0]   cond;
        logic [15:0]  imm;
    } instr_fields_t;

    function automatic logic is_alu_op(input logic [4:0] op);
        return ((op >= 5'd17) && (op <= 5'd21)) || ((op >= 5'd25) && (op <= 5'd29));
    endfunction

    function automatic logic is_legal(input instr_fields_t f);
        logic ok;
        ok = 1'b0;
        case (f.cls)
            CLS_DIMM: ok = (f.op <= 5'd5) || is_alu_op(f.op);
            CLS_DREG: ok = is_alu_op(f.op) || (f.op == OP_NOT);
            CLS_LS:   ok = (f.op[4:1] == 4'd0);
            CLS_SYS:  ok = !f.op[4] &&
                           (f.op[3:0] inside {SYS_B, SYS_BCOND, SYS_BR, SYS_NOP, SYS_HALT});
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] pack_fields(input instr_fields_t f);
        logic [31:0] w;
        w = '0;
        w[CLS_LO +: 2] = f.cls;
        case (f.cls)
            CLS_DIMM: begin
                w[OP_LO +: 5] = f.op;
                w[RD_LO +: 3] = f.rd;
                if ((f.op != OP_MOV) && (f.op != OP_MOVT))
                    w[RS1_LO +: 3] = f.rs1;
                w[15:0] = f.imm;
            end
            CLS_DREG: begin
                w[OP_LO +: 5]  = f.op;
                w[RD_LO +: 3]  = f.rd;
                w[RS1_LO +: 3] = f.rs1;
                if (f.op != OP_NOT)
                    w[RS2_LO +: 3] = f.rs2;
            end
            CLS_LS: begin
                w[OP_LO]       = f.op[0];
                w[RD_LO +: 3]  = f.rd;
                w[RS1_LO +: 3] = f.rs1;
                w[15:0]        = f.imm;
            end
            default: begin
                w[OP_LO +: 4] = f.op[3:0];
                case (f.op[3:0])
                    SYS_B:     w[15:0] = f.imm;
                    SYS_BCOND: begin
                        w[COND_LO +: 4] = f.cond;
                        w[15:0]         = f.imm;
                    end
                    SYS_BR: begin
                        w[RS1_LO +: 3] = f.rs1;
                        w[15:0]        = f.imm;
                    end
                    default: ;
                endcase
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry valid/ready buffer holding {address, word} pairs for the
// instruction-memory write port.
module instr_fifo2 #(
    parameter int unsigned W = 42
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_do_push;
    logic         w_do_pop;

    assign w_do_pop  = i_pop && (r_count != 2'd0);
    // A push into a full buffer is only allowed when the head leaves the same cycle.
    assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop)
                r_rd_ptr <= ~r_rd_ptr;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_encoder.sv
// Field-to-word instruction encoder: validates decoded field bundles, packs
// them into ISA words and streams them with incrementing addresses to memory.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_class,
    input  logic [4:0]          in_op,
    input  logic [2:0]          in_rd,
    input  logic [2:0]          in_rs1,
    input  logic [2:0]          in_rs2,
    input  logic [3:0]          in_cond,
    input  logic [15:0]         in_imm,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                overflow
);

    enc_state_e            r_state;
    enc_state_e            w_state_next;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_err;
    logic [ERRCNT_W-1:0]   r_err_count;
    logic                  r_overflow;
    logic                  r_done;

    instr_fields_t         w_fields;
    logic                  w_legal;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_is_halt;
    logic                  w_last_addr;
    logic                  w_start_ok;
    logic [1:0]            w_fifo_count;
    logic [ADDR_W+31:0]    w_head;

    always_comb begin
        w_fields.cls  = instr_class_e'(in_class);
        w_fields.op   = in_op;
        w_fields.rd   = in_rd;
        w_fields.rs1  = in_rs1;
        w_fields.rs2  = in_rs2;
        w_fields.cond = in_cond;
        w_fields.imm  = in_imm;
    end

    assign w_legal     = is_legal(w_fields);
    assign in_ready    = (r_state == ST_RUN) && (w_fifo_count < 2'd2);
    assign w_accept    = in_valid && in_ready;
    assign w_push      = w_accept && w_legal;
    assign w_pop       = mem_valid && mem_ready;
    assign w_is_halt   = (in_class == CLS_SYS) && (in_op == {1'b0, SYS_HALT});
    assign w_last_addr = (r_addr == '1);
    assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_state_next = ST_RUN;
            ST_RUN:   if (w_push && (w_is_halt || w_last_addr)) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_fifo_count == 2'd0) w_state_next = ST_DONE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_overflow  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_addr      <= base_addr;
                r_err       <= 1'b0;
                r_err_count <= '0;
                r_overflow  <= 1'b0;
                r_done      <= 1'b0;
            end else begin
                // The address wraps naturally; the state change stops further accepts.
                if (w_push) begin
                    r_addr <= r_addr + ADDR_W'(1);
                    if (w_last_addr) begin
                        r_overflow <= 1'b1;
                        r_done     <= 1'b1;
                    end
                end
                if (w_accept && !w_legal) begin
                    r_err <= 1'b1;
                    if (r_err_count != '1)
                        r_err_count <= r_err_count + ERRCNT_W'(1);
                end
                if ((r_state == ST_DRAIN) && (w_state_next == ST_DONE))
                    r_done <= 1'b1;
            end
        end
    end

    instr_fifo2 #(
        .W(ADDR_W + 32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ({r_addr, pack_fields(w_fields)}),
        .i_pop   (w_pop),
        .o_valid (mem_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign mem_addr  = w_head[32 +: ADDR_W];
    assign mem_wdata = w_head[31:0];
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done      = r_done;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: a 10-bit-address instance
// for packing/handshake scenarios and a 4-bit one for overflow/saturation.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_class;
    logic [4:0]  in_op;
    logic [2:0]  in_rd, in_rs1, in_rs2;
    logic [3:0]  in_cond;
    logic [15:0] in_imm;
    logic        mem_valid, mem_ready;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err, overflow;
    logic [7:0]  err_count;

    logic        d4_start;
    logic [3:0]  d4_base;
    logic        d4_in_valid, d4_in_ready;
    logic        d4_mem_valid, d4_mem_ready;
    logic [3:0]  d4_mem_addr;
    logic [31:0] d4_mem_wdata;
    logic        d4_busy, d4_done, d4_err, d4_overflow;
    logic [2:0]  d4_err_count;

    int checks = 0;
    int errors = 0;
    logic [41:0] wr_log [$];
    logic [35:0] d4_log [$];

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .ERRCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_cond(in_cond), .in_imm(in_imm),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .err_count(err_count), .overflow(overflow)
    );

    instr_encoder #(.ADDR_W(4), .ERRCNT_W(3)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(d4_start), .base_addr(d4_base),
        .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_class(in_class), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_cond(in_cond), .in_imm(in_imm),
        .mem_valid(d4_mem_valid), .mem_ready(d4_mem_ready), .mem_addr(d4_mem_addr),
        .mem_wdata(d4_mem_wdata), .busy(d4_busy), .done(d4_done), .err(d4_err),
        .err_count(d4_err_count), .overflow(d4_overflow)
    );

    always @(posedge clk) begin
        if (rst_n && mem_valid && mem_ready) wr_log.push_back({mem_addr, mem_wdata});
        if (rst_n && d4_mem_valid && d4_mem_ready) d4_log.push_back({d4_mem_addr, d4_mem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [1:0] c, input logic [4:0] o, input logic [2:0] rd,
                          input logic [2:0] rs1, input logic [2:0] rs2,
                          input logic [3:0] cd, input logic [15:0] im);
        in_class = c; in_op = o; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_cond = cd; in_imm = im;
    endtask

    task automatic reset_all();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; base_addr = '0;
        d4_start = 1'b0; d4_in_valid = 1'b0; d4_mem_ready = 1'b0; d4_base = '0;
        bundle(2'b00, 5'd0, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        wr_log.delete();
        d4_log.delete();
    endtask

    task automatic start_main(input logic [9:0] b);
        base_addr = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_all();
        checks++;
        if ({in_ready, mem_valid, busy, done, err, overflow} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {in_ready, mem_valid, busy, done, err, overflow});
        end
        checks++;
        if ({err_count, mem_addr, mem_wdata} !== 50'h0) begin
            errors++;
            $display("FAIL reset_values: got cnt=%h addr=%h data=%h expected all 0",
                     err_count, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_data_imm();
        reset_all();
        start_main(10'h010);
        checks++;
        if ({busy, in_ready} !== 2'b11) begin
            errors++; $display("FAIL dimm_run: got busy/in_ready=%b expected 11", {busy, in_ready});
        end
        mem_ready = 1'b1;
        bundle(2'b00, 5'b11001, 3'd3, 3'd1, 3'd0, 4'd0, 16'h0005);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 10'h010, 32'h32C80005}) begin
            errors++;
            $display("FAIL dimm_word: got v=%b addr=%h data=%h expected v=1 addr=010 data=32c80005",
                     mem_valid, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (mem_valid !== 1'b0 || wr_log.size() != 1) begin
            errors++;
            $display("FAIL dimm_pop: got mem_valid=%b writes=%0d expected 0 and 1", mem_valid, wr_log.size());
        end
    endtask

    task automatic test_backpressure();
        reset_all();
        start_main(10'h010);
        mem_ready = 1'b0;
        bundle(2'b10, 5'b00001, 3'd2, 3'd5, 3'd0, 4'd0, 16'h0010);
        in_valid = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready1: got %b expected 1", in_ready);
        end
        bundle(2'b11, 5'b00000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0004);
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_ready2: got %b expected 0", in_ready);
        end
        checks++;
        if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 10'h010, 32'h82A80010}) begin
            errors++;
            $display("FAIL bp_head: got v=%b addr=%h data=%h expected v=1 addr=010 data=82a80010",
                     mem_valid, mem_addr, mem_wdata);
        end
        tick();
        checks++;
        if (wr_log.size() != 0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got writes=%0d in_ready=%b expected 0 and 0", wr_log.size(), in_ready);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 20 && wr_log.size() < 2; i++) tick();
        checks++;
        if (wr_log.size() != 2) begin
            errors++; $display("FAIL bp_count: got %0d writes expected 2", wr_log.size());
        end
        checks++;
        if (wr_log[0] !== {10'h010, 32'h82A80010} || wr_log[1] !== {10'h011, 32'hC0000004}) begin
            errors++;
            $display("FAIL bp_order: got %h %h expected 01082a80010 011c0000004", wr_log[0], wr_log[1]);
        end
    endtask

    task automatic test_illegal_then_legal();
        reset_all();
        start_main(10'h010);
        mem_ready = 1'b1;
        bundle(2'b01, 5'b00000, 3'd1, 3'd1, 3'd1, 4'd0, 16'h0);
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL ill_ready: got %b expected 1", in_ready);
        end
        tick();
        checks++;
        if ({err, err_count, mem_valid} !== {1'b1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL ill_flags: got err=%b cnt=%0d mem_valid=%b expected 1 1 0", err, err_count, mem_valid);
        end
        // start during RUN must not reload the address or clear err
        start = 1'b1; base_addr = 10'h200;
        bundle(2'b11, 5'b00001, 3'd0, 3'd0, 3'd0, 4'd3, 16'hFFFC);
        tick();
        start = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 20 && wr_log.size() < 1; i++) tick();
        tick(); tick();
        checks++;
        if (wr_log.size() != 1 || wr_log[0] !== {10'h010, 32'hC260FFFC}) begin
            errors++;
            $display("FAIL ill_write: got n=%0d first=%h expected 1 010c260fffc", wr_log.size(), wr_log[0]);
        end
        checks++;
        if ({busy, err, err_count} !== {1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL ill_start_ignored: got busy=%b err=%b cnt=%0d expected 1 1 1", busy, err, err_count);
        end
    endtask

    task automatic test_pack_back_to_back();
        logic [35:0] vec [5];
        logic [41:0] exp [4];
        vec = '{{2'b01, 5'b10110, 3'd1, 3'd2, 3'd7, 4'd0, 16'h0000},
                {2'b01, 5'b10001, 3'd7, 3'd0, 3'd5, 4'd0, 16'h0000},
                {2'b11, 5'b10000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0000},
                {2'b10, 5'b00000, 3'd4, 3'd3, 3'd0, 4'd0, 16'hABCD},
                {2'b11, 5'b00010, 3'd0, 3'd6, 3'd0, 4'd0, 16'h1234}};
        exp = '{{10'h100, 32'h6C500000}, {10'h101, 32'h63C50000},
                {10'h102, 32'h8118ABCD}, {10'h103, 32'hC4301234}};
        reset_all();
        start_main(10'h100);
        mem_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            {in_class, in_op, in_rd, in_rs1, in_rs2, in_cond, in_imm} = vec[i];
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && wr_log.size() < 4; i++) tick();
        checks++;
        if (wr_log.size() != 4 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL pack_count: got writes=%0d err_count=%0d expected 4 1", wr_log.size(), err_count);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wr_log[i] !== exp[i]) begin
                errors++; $display("FAIL pack_word%0d: got %h expected %h", i, wr_log[i], exp[i]);
            end
        end
    endtask

    task automatic test_halt_drain();
        reset_all();
        start_main(10'h020);
        mem_ready = 1'b1;
        bundle(2'b11, 5'b00100, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
        in_valid = 1'b1;
        tick();
        bundle(2'b11, 5'b01000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, busy} !== 2'b01) begin
            errors++; $display("FAIL halt_drain: got in_ready/busy=%b expected 01", {in_ready, busy});
        end
        for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
        checks++;
        if ({done, busy, in_ready, mem_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL halt_done: got done/busy/in_ready/mem_valid=%b expected 1000",
                     {done, busy, in_ready, mem_valid});
        end
        checks++;
        if (wr_log.size() != 2 || wr_log[0] !== {10'h020, 32'hC8000000} || wr_log[1] !== {10'h021, 32'hD0000000}) begin
            errors++;
            $display("FAIL halt_words: got n=%0d %h %h expected 2 020c8000000 021d0000000",
                     wr_log.size(), wr_log[0], wr_log[1]);
        end
        start_main(10'h030);
        checks++;
        if ({done, busy, in_ready} !== 3'b011) begin
            errors++; $display("FAIL halt_restart: got done/busy/in_ready=%b expected 011", {done, busy, in_ready});
        end
    endtask

    task automatic test_overflow_and_saturation();
        reset_all();
        d4_base = 4'hE; d4_start = 1'b1;
        tick();
        d4_start = 1'b0;
        d4_mem_ready = 1'b1;
        bundle(2'b11, 5'b00000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0001);
        d4_in_valid = 1'b1;
        tick();
        bundle(2'b11, 5'b00000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0002);
        tick();
        checks++;
        if ({d4_overflow, d4_done, d4_in_ready} !== 3'b110) begin
            errors++;
            $display("FAIL ovf_flags: got overflow/done/in_ready=%b expected 110", {d4_overflow, d4_done, d4_in_ready});
        end
        bundle(2'b11, 5'b00000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0003);
        for (int i = 0; i < 5; i++) tick();
        d4_in_valid = 1'b0;
        checks++;
        if (d4_log.size() != 2 || d4_log[0] !== {4'hE, 32'hC0000001} || d4_log[1] !== {4'hF, 32'hC0000002}) begin
            errors++;
            $display("FAIL ovf_words: got n=%0d %h %h expected 2 ec0000001 fc0000002",
                     d4_log.size(), d4_log[0], d4_log[1]);
        end
        checks++;
        if ({d4_busy, d4_done, d4_overflow} !== 3'b011) begin
            errors++; $display("FAIL ovf_state: got busy/done/overflow=%b expected 011", {d4_busy, d4_done, d4_overflow});
        end
        d4_base = 4'h0; d4_start = 1'b1;
        tick();
        d4_start = 1'b0;
        checks++;
        if ({d4_overflow, d4_done, d4_busy} !== 3'b001) begin
            errors++; $display("FAIL ovf_restart: got overflow/done/busy=%b expected 001", {d4_overflow, d4_done, d4_busy});
        end
        d4_in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            case (i % 3)
                0:       bundle(2'b10, 5'b00010, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
                1:       bundle(2'b11, 5'b00011, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
                default: bundle(2'b00, 5'b00110, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
            endcase
            tick();
        end
        d4_in_valid = 1'b0;
        checks++;
        if ({d4_err, d4_err_count, d4_mem_valid} !== {1'b1, 3'b111, 1'b0} || d4_log.size() != 2) begin
            errors++;
            $display("FAIL sat_count: got err=%b cnt=%0d mem_valid=%b writes=%0d expected 1 7 0 2",
                     d4_err, d4_err_count, d4_mem_valid, d4_log.size());
        end
    endtask

    task automatic test_reset_mid();
        reset_all();
        start_main(10'h040);
        mem_ready = 1'b0;
        in_valid = 1'b1;
        bundle(2'b11, 5'b00011, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
        tick();
        bundle(2'b11, 5'b00000, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0007);
        tick();
        bundle(2'b11, 5'b00100, 3'd0, 3'd0, 3'd0, 4'd0, 16'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, mem_valid, err} !== 3'b011) begin
            errors++; $display("FAIL mid_full: got in_ready/mem_valid/err=%b expected 011", {in_ready, mem_valid, err});
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({mem_valid, busy, in_ready, done, err, overflow} !== 6'b0 || {err_count, mem_addr} !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset: got flags=%b cnt=%0d addr=%h expected 0",
                     {mem_valid, busy, in_ready, done, err, overflow}, err_count, mem_addr);
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (wr_log.size() != 0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_dropped: got writes=%0d mem_valid=%b expected 0 0", wr_log.size(), mem_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_data_imm();
        test_backpressure();
        test_illegal_then_legal();
        test_pack_back_to_back();
        test_halt_drain();
        test_overflow_and_saturation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
